// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one external single-port memory bus between the instruction-fetch
// path and the data-memory path. Only one transaction is outstanding at a
// time. Data requests win by default. A starvation counter forces a pending
// fetch to win after MAX_STARVE consecutive lost arbitrations. An optional
// timeout aborts a transaction the memory never completes and reports it
// with bus_err.
//
// Parameters:
//   MAX_STARVE  data grants a pending fetch may lose in a row (1..15)
//   TIMEOUT     BUSY cycles without ext_valid before abort (0 = disabled)
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_req/if_addr                fetch read request (held until if_gnt)
//   if_gnt                        fetch accepted (combinational, IDLE only)
//   if_rvalid/if_rdata            one-cycle fetch completion + data
//   d_req/d_we/d_addr/d_wdata/d_wstrb
//                                 data request (held until d_gnt)
//   d_gnt                         data accepted (combinational, IDLE only)
//   d_rvalid/d_rdata              one-cycle data completion (rdata 0 on write)
//   ext_ren/ext_wen               external strobes, held until ext_valid
//   ext_addr/ext_wdata/ext_wstrb  external request, stable while strobed
//   ext_valid/ext_rdata           external completion and read data
//   stall                         pipeline hold request
//   bus_err                       pulses with rvalid on a timeout abort
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int MAX_STARVE = 3,
    parameter int TIMEOUT    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        ext_ren,
    output logic        ext_wen,
    output logic [31:0] ext_addr,
    output logic [31:0] ext_wdata,
    output logic [3:0]  ext_wstrb,
    input  logic        ext_valid,
    input  logic [31:0] ext_rdata,
    output logic        stall,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIMIT = 4'(MAX_STARVE);
    localparam bit         TIMEOUT_EN   = (TIMEOUT > 0);
    // Last BUSY cycle allowed: the strobe is held for exactly TIMEOUT cycles.
    localparam logic [7:0] WAIT_LAST    = TIMEOUT_EN ? 8'(TIMEOUT - 1) : 8'd0;

    state_t      state;
    state_t      state_next;
    logic [3:0]  starve_cnt;
    logic [7:0]  wait_cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] rdata_q;
    logic        if_rvalid_q;
    logic        d_rvalid_q;
    logic        bus_err_q;
    logic        done;
    logic        abort;

    // Arbitration and next-state logic.
    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        done       = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                // No grants while reset is held, so nothing is accepted
                // that the reset would then silently discard.
                if (!rst) begin
                    if (if_req && (!d_req || starve_cnt == STARVE_LIMIT)) begin
                        if_gnt     = 1'b1;
                        state_next = BUSY_IF;
                    end else if (d_req) begin
                        d_gnt      = 1'b1;
                        state_next = BUSY_D;
                    end
                end
            end
            BUSY_IF, BUSY_D: begin
                // A completion in the timeout cycle is a normal completion.
                if (ext_valid) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end else if (TIMEOUT_EN && wait_cnt == WAIT_LAST) begin
                    abort      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            wait_cnt    <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state       <= state_next;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            bus_err_q   <= 1'b0;

            if (if_gnt) begin
                addr_q     <= if_addr;
                we_q       <= 1'b0;
                wdata_q    <= '0;
                wstrb_q    <= '0;
                wait_cnt   <= '0;
                starve_cnt <= '0;
            end

            if (d_gnt) begin
                addr_q   <= d_addr;
                we_q     <= d_we;
                wdata_q  <= d_we ? d_wdata : 32'd0;
                wstrb_q  <= d_we ? d_wstrb : 4'd0;
                wait_cnt <= '0;
                // Only a fetch that actually lost this arbitration counts.
                if (if_req && starve_cnt != STARVE_LIMIT) begin
                    starve_cnt <= starve_cnt + 4'd1;
                end
            end

            if (state != IDLE) begin
                wait_cnt <= wait_cnt + 8'd1;
            end

            if (done || abort) begin
                if_rvalid_q <= (state == BUSY_IF);
                d_rvalid_q  <= (state == BUSY_D);
                bus_err_q   <= abort;
                rdata_q     <= (abort || we_q) ? 32'd0 : ext_rdata;
            end
        end
    end

    assign ext_ren   = (state != IDLE) && !we_q;
    assign ext_wen   = (state != IDLE) &&  we_q;
    assign ext_addr  = addr_q;
    assign ext_wdata = wdata_q;
    assign ext_wstrb = wstrb_q;

    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign if_rdata  = if_rvalid_q ? rdata_q : 32'd0;
    assign d_rdata   = d_rvalid_q  ? rdata_q : 32'd0;
    assign bus_err   = bus_err_q;

    assign stall = !rst && ((state != IDLE) || (if_req && !if_gnt) || (d_req && !d_gnt));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter (MAX_STARVE=3, TIMEOUT=8).
// A behavioural memory answers strobes after a programmable number of wait
// states. Each grant pushes the expected completion onto a per-requester
// queue; a monitor pops and compares on every rvalid.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        ext_ren;
    logic        ext_wen;
    logic [31:0] ext_addr;
    logic [31:0] ext_wdata;
    logic [3:0]  ext_wstrb;
    logic        ext_valid;
    logic [31:0] ext_rdata;
    logic        stall;
    logic        bus_err;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_if[$];
    exp_t exp_d[$];

    // Memory model controls.
    int   mem_wait    = 0;
    bit   mem_mute    = 1'b0;
    bit   force_valid = 1'b0;
    int   busy_cnt    = 0;

    mem_port_arbiter #(
        .MAX_STARVE (3),
        .TIMEOUT    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .ext_ren   (ext_ren),
        .ext_wen   (ext_wen),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .ext_wstrb (ext_wstrb),
        .ext_valid (ext_valid),
        .ext_rdata (ext_rdata),
        .stall     (stall),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'h0000_0100) return 32'h0050_0093;
        return {~addr[15:0], addr[15:0]};
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] data, input logic err);
        exp_t e;
        e.data = data;
        e.err  = err;
        return e;
    endfunction

    // Behavioural memory: evaluated a little after each falling edge so it
    // sees the control flags the test tasks set on that same edge.
    initial begin
        ext_valid = 1'b0;
        ext_rdata = 32'hBAD0_BAD0;
        forever begin
            @(negedge clk);
            #2;
            if (ext_ren || ext_wen) busy_cnt++;
            else                    busy_cnt = 0;
            ext_valid = force_valid ||
                        (!mem_mute && (ext_ren || ext_wen) && busy_cnt > mem_wait);
            ext_rdata = ext_valid ? mem_word(ext_addr) : 32'hBAD0_BAD0;
        end
    end

    // Completion monitor / scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (if_rvalid || d_rvalid) begin
                n_checks++;
                if (if_rvalid && d_rvalid) begin
                    n_fail++;
                    $display("FAIL rvalid_exclusive: if_rvalid=%0b d_rvalid=%0b, required not both", if_rvalid, d_rvalid);
                end
            end
            if (bus_err && !if_rvalid && !d_rvalid) begin
                n_checks++;
                n_fail++;
                $display("FAIL bus_err_alone: bus_err=1 without rvalid");
            end
            if (if_rvalid) begin
                n_checks++;
                if (exp_if.size() == 0) begin
                    n_fail++;
                    $display("FAIL if_unexpected: if_rvalid with rdata=%h err=%0b, required no completion", if_rdata, bus_err);
                end else begin
                    e = exp_if.pop_front();
                    if ({if_rdata, bus_err} !== e) begin
                        n_fail++;
                        $display("FAIL if_completion: rdata=%h err=%0b, required rdata=%h err=%0b", if_rdata, bus_err, e.data, e.err);
                    end
                end
            end
            if (d_rvalid) begin
                n_checks++;
                if (exp_d.size() == 0) begin
                    n_fail++;
                    $display("FAIL d_unexpected: d_rvalid with rdata=%h err=%0b, required no completion", d_rdata, bus_err);
                end else begin
                    e = exp_d.pop_front();
                    if ({d_rdata, bus_err} !== e) begin
                        n_fail++;
                        $display("FAIL d_completion: rdata=%h err=%0b, required rdata=%h err=%0b", d_rdata, bus_err, e.data, e.err);
                    end
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check_drained(input string tag);
        #3;
        n_checks++;
        if (exp_if.size() != 0 || exp_d.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drained: pending if=%0d d=%0d, required 0 0", tag, exp_if.size(), exp_d.size());
        end
    endtask

    task automatic test_reset();
        logic [139:0] outs;
        rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h0000_0500;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0600;
        d_wdata = '0; d_wstrb = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            outs = {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, ext_ren, ext_wen,
                    ext_addr, ext_wdata, ext_wstrb, stall, bus_err};
            n_checks++;
            if (outs !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs_%0d: outputs=%h, required all 0", i, outs);
            end
        end
        rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        #1;
        outs = {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, ext_ren, ext_wen,
                ext_addr, ext_wdata, ext_wstrb, stall, bus_err};
        n_checks++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_release: outputs=%h, required all 0", outs);
        end
    endtask

    task automatic test_zero_wait_fetch();
        mem_wait = 0;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0000_0100;
        #1;
        n_checks++;
        if ({if_gnt, d_gnt} !== 2'b10) begin
            n_fail++;
            $display("FAIL fetch_gnt: if_gnt=%0b d_gnt=%0b, required 1 0", if_gnt, d_gnt);
        end
        exp_if.push_back(mk_exp(32'h0050_0093, 1'b0));
        @(negedge clk);
        if_req = 1'b0; if_addr = '0;
        n_checks++;
        if ({ext_ren, ext_wen, ext_addr, ext_wstrb, ext_wdata} !== {2'b10, 32'h100, 4'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL fetch_strobe: ren=%0b wen=%0b addr=%h wstrb=%h wdata=%h, required 1 0 00000100 0 0",
                     ext_ren, ext_wen, ext_addr, ext_wstrb, ext_wdata);
        end
        @(negedge clk);
        n_checks++;
        if ({if_rvalid, if_rdata} !== {1'b1, 32'h0050_0093}) begin
            n_fail++;
            $display("FAIL fetch_rvalid: rvalid=%0b rdata=%h, required 1 00500093", if_rvalid, if_rdata);
        end
        check_drained("fetch");
    endtask

    task automatic test_write_wait_states();
        int n = 0;
        mem_wait = 2;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0040;
        d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'b0011;
        #1;
        n_checks++;
        if ({if_gnt, d_gnt} !== 2'b01) begin
            n_fail++;
            $display("FAIL write_gnt: if_gnt=%0b d_gnt=%0b, required 0 1", if_gnt, d_gnt);
        end
        exp_d.push_back(mk_exp(32'h0, 1'b0));
        @(negedge clk);
        d_req = 1'b0; d_we = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (!ext_wen) break;
            n++;
            n_checks++;
            if ({ext_ren, ext_addr, ext_wdata, ext_wstrb, stall} !== {1'b0, 32'h40, 32'hDEAD_BEEF, 4'b0011, 1'b1}) begin
                n_fail++;
                $display("FAIL write_busy_%0d: ren=%0b addr=%h wdata=%h wstrb=%b stall=%0b, required 0 00000040 deadbeef 0011 1",
                         n, ext_ren, ext_addr, ext_wdata, ext_wstrb, stall);
            end
            @(negedge clk);
        end
        n_checks++;
        if (n != 3) begin
            n_fail++;
            $display("FAIL write_strobe_len: ext_wen cycles=%0d, required 3", n);
        end
        n_checks++;
        if ({d_rvalid, d_rdata, bus_err} !== {1'b1, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL write_done: rvalid=%0b rdata=%h err=%0b, required 1 00000000 0", d_rvalid, d_rdata, bus_err);
        end
        mem_wait = 0;
        check_drained("write");
    endtask

    // Both requesters held high; grant pattern must be D,D,D,IF repeating.
    task automatic run_contention(input int n_grants, input string tag);
        int  g = 0;
        bit  exp_d_win;
        bit  got_if;
        bit  got_d;
        mem_wait = 0;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0000_1000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_2000;
        for (int c = 0; c < 8 * n_grants && g < n_grants; c++) begin
            #1;
            got_if = if_gnt;
            got_d  = d_gnt;
            if (got_if || got_d) begin
                exp_d_win = (g % 4) != 3;
                n_checks++;
                if ({got_if, got_d} !== {!exp_d_win, exp_d_win}) begin
                    n_fail++;
                    $display("FAIL %s_order_%0d: if_gnt=%0b d_gnt=%0b, required %0b %0b",
                             tag, g, got_if, got_d, !exp_d_win, exp_d_win);
                end
                if (got_if) exp_if.push_back(mk_exp(mem_word(if_addr), 1'b0));
                if (got_d)  exp_d.push_back(mk_exp(mem_word(d_addr), 1'b0));
                g++;
            end
            @(negedge clk);
            if (got_if) if_addr = if_addr + 32'd4;
            if (got_d)  d_addr  = d_addr + 32'd4;
        end
        if_req = 1'b0; d_req = 1'b0;
        n_checks++;
        if (g != n_grants) begin
            n_fail++;
            $display("FAIL %s_grant_count: grants=%0d, required %0d", tag, g, n_grants);
        end
        wait_cycles(3);
        check_drained(tag);
    endtask

    task automatic test_contention();
        run_contention(8, "contention");
    endtask

    task automatic test_timeout();
        int n = 0;
        mem_mute = 1'b1;
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0080;
        #1;
        n_checks++;
        if (d_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_gnt: d_gnt=%0b, required 1", d_gnt);
        end
        exp_d.push_back(mk_exp(32'h0, 1'b1));
        @(negedge clk);
        d_req = 1'b0;
        while (ext_ren && n < 40) begin
            n++;
            @(negedge clk);
        end
        n_checks++;
        if (n != 8) begin
            n_fail++;
            $display("FAIL timeout_strobe_len: ext_ren cycles=%0d, required 8", n);
        end
        n_checks++;
        if ({d_rvalid, bus_err, d_rdata, if_rvalid} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL timeout_abort: d_rvalid=%0b bus_err=%0b rdata=%h if_rvalid=%0b, required 1 1 00000000 0",
                     d_rvalid, bus_err, d_rdata, if_rvalid);
        end
        mem_mute = 1'b0;
        // The next fetch proceeds normally.
        if_req = 1'b1; if_addr = 32'h0000_0104;
        #1;
        n_checks++;
        if (if_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_next_gnt: if_gnt=%0b, required 1", if_gnt);
        end
        exp_if.push_back(mk_exp(mem_word(32'h0000_0104), 1'b0));
        @(negedge clk);
        if_req = 1'b0;
        wait_cycles(2);
        check_drained("timeout");
    endtask

    task automatic test_reset_mid_busy();
        mem_mute = 1'b1;
        @(negedge clk);
        // Fetch loses this arbitration, so the starvation count becomes 1.
        if_req = 1'b1; if_addr = 32'h0000_0200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
        #1;
        n_checks++;
        if ({if_gnt, d_gnt} !== 2'b01) begin
            n_fail++;
            $display("FAIL midrst_gnt: if_gnt=%0b d_gnt=%0b, required 0 1", if_gnt, d_gnt);
        end
        @(negedge clk);
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        // Second BUSY cycle: reset and completion arrive together.
        rst = 1'b1;
        force_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({ext_ren, ext_wen, if_rvalid, d_rvalid, bus_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL midrst_idle: ren=%0b wen=%0b if_rvalid=%0b d_rvalid=%0b err=%0b, required all 0",
                     ext_ren, ext_wen, if_rvalid, d_rvalid, bus_err);
        end
        // ext_valid while IDLE must be ignored.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if ({ext_ren, ext_wen, if_rvalid, d_rvalid, bus_err} !== 5'b0) begin
                n_fail++;
                $display("FAIL midrst_quiet_%0d: ren=%0b wen=%0b if_rvalid=%0b d_rvalid=%0b err=%0b, required all 0",
                         i, ext_ren, ext_wen, if_rvalid, d_rvalid, bus_err);
            end
        end
        force_valid = 1'b0;
        mem_mute = 1'b0;
        wait_cycles(1);
        // A cleared starvation count gives D,D,D,IF again.
        run_contention(4, "midrst_starve");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_zero_wait_fetch();
        test_write_wait_states();
        test_contention();
        test_timeout();
        test_reset_mid_busy();
        wait_cycles(2);
        check_drained("final");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
